// File: rtl/exc_vector_ctrl.sv
// exc_vector_ctrl: multicycle-MIPS exception sequencer (EPC save, vector fetch, PC load).
// Define EXC_VECTOR_COUNT_EN to add the saturating exc_count output.
module exc_vector_ctrl #(
  parameter logic [31:0] EPC_OFFSET = 32'd4,
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic exc_opcode,
  input  logic exc_overflow,
  input  logic exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0] vec_sel,
  output logic mem_rd,
  output logic [31:0] epc_out,
  output logic epc_wr,
  output logic [31:0] pc_out,
  output logic pc_wr,
  output logic [1:0] exc_code,
  output logic busy
`ifdef EXC_VECTOR_COUNT_EN
  ,output logic [7:0] exc_count
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ADDR, S_WAIT, S_LOAD} state_t;
  localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n, vec_n;
  logic [1:0] code_n;
  logic [31:0] epc_n, pc_n;
  logic unused_data;
  assign unused_data = ^mem_data_in[31:8];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    vec_n = vec_sel;
    code_n = exc_code;
    epc_n = epc_out;
    pc_n = pc_out;
    case (state)
      S_IDLE: if (exc_opcode | exc_overflow | exc_div0) begin
        state_n = S_CAPTURE;
        code_n = exc_opcode ? 2'b01 : exc_overflow ? 2'b10 : 2'b11;
        vec_n = exc_opcode ? 3'b010 : exc_overflow ? 3'b011 : 3'b100;
        epc_n = pc_in - EPC_OFFSET;
      end
      S_CAPTURE: state_n = S_ADDR;
      S_ADDR: begin
        state_n = S_WAIT;
        cnt_n = '0;
      end
      S_WAIT: if (cnt == LAST) begin
        state_n = S_LOAD;
        pc_n = {24'b0, mem_data_in[7:0]};
      end else cnt_n = cnt + 3'd1;
      S_LOAD: begin
        state_n = S_IDLE;
        vec_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // strobes are decoded from the next state so every output is a flop
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      vec_sel <= '0;
      exc_code <= '0;
      epc_out <= '0;
      pc_out <= '0;
      epc_wr <= 1'b0;
      mem_rd <= 1'b0;
      pc_wr <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      vec_sel <= vec_n;
      exc_code <= code_n;
      epc_out <= epc_n;
      pc_out <= pc_n;
      epc_wr <= state_n == S_CAPTURE;
      mem_rd <= state_n == S_ADDR;
      pc_wr <= state_n == S_LOAD;
      busy <= state_n != S_IDLE;
    end
`ifdef EXC_VECTOR_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) exc_count <= '0;
    else if (state == S_LOAD && exc_count != 8'hFF) exc_count <= exc_count + 8'd1;
`endif
endmodule

// File: tb/tb_exc_vector_ctrl.sv
// tb_exc_vector_ctrl: table-driven scoreboard bench for exc_vector_ctrl (MEM_LATENCY 1 and 3).
module tb_exc_vector_ctrl;
  localparam int ML = 1;
  typedef struct {
    logic op, ov, dz;
    logic [31:0] pc, mem;
    logic [1:0] code;
    logic [2:0] vsel;
    logic [31:0] epc, pco;
  } vec_t;
  typedef struct {
    logic [1:0] code;
    logic [2:0] vsel;
    logic [31:0] epc, pco;
    int s;
  } exp_t;
  logic clk = 0, reset;
  logic exc_opcode = 0, exc_overflow = 0, exc_div0 = 0;
  logic f3_op = 0, f3_ov = 0, f3_dz = 0;
  logic [31:0] pc_in = 0, mem_data_in = 0;
  logic [2:0] vec_sel, vec_sel3;
  logic mem_rd, epc_wr, pc_wr, busy, mem_rd3, epc_wr3, pc_wr3, busy3;
  logic [31:0] epc_out, pc_out, epc_out3, pc_out3;
  logic [1:0] exc_code, exc_code3;
`ifdef EXC_VECTOR_COUNT_EN
  logic [7:0] exc_count, exc_count3;
`endif
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [1:0] last_code = 0;
  exp_t q[$];
  vec_t tbl[5];
  exc_vector_ctrl #(.MEM_LATENCY(ML)) dut (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_div0(exc_div0), .pc_in(pc_in), .mem_data_in(mem_data_in), .vec_sel(vec_sel),
    .mem_rd(mem_rd), .epc_out(epc_out), .epc_wr(epc_wr), .pc_out(pc_out), .pc_wr(pc_wr),
    .exc_code(exc_code), .busy(busy)
`ifdef EXC_VECTOR_COUNT_EN
    , .exc_count(exc_count)
`endif
  );
  exc_vector_ctrl #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .exc_opcode(f3_op), .exc_overflow(f3_ov),
    .exc_div0(f3_dz), .pc_in(pc_in), .mem_data_in(mem_data_in), .vec_sel(vec_sel3),
    .mem_rd(mem_rd3), .epc_out(epc_out3), .epc_wr(epc_wr3), .pc_out(pc_out3), .pc_wr(pc_wr3),
    .exc_code(exc_code3), .busy(busy3)
`ifdef EXC_VECTOR_COUNT_EN
    , .exc_count(exc_count3)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push(input vec_t v, input int s);
    exp_t e;
    e.code = v.code;
    e.vsel = v.vsel;
    e.epc = v.epc;
    e.pco = v.pco;
    e.s = s;
    q.push_back(e);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic drive(input vec_t v);
    exc_opcode = v.op;
    exc_overflow = v.ov;
    exc_div0 = v.dz;
    pc_in = v.pc;
    mem_data_in = v.mem;
  endtask
  task automatic run_vec(input vec_t v);
    step(1);
    drive(v);
    push(v, cyc + 1);
    step(1);
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    step(6);
  endtask
  // scoreboard monitor for the MEM_LATENCY=1 instance
  always @(negedge clk) begin
    exp_t e;
    int k;
    if (q.size() == 0 || cyc < q[0].s) begin
      chk("idle_quiet", {busy, epc_wr, mem_rd, pc_wr}, 4'b0);
      chk("idle_vec", vec_sel, 3'b000);
      chk("code_hold", exc_code, last_code);
    end else begin
      e = q[0];
      k = cyc - e.s;
      chk("busy", busy, 1'b1);
      chk("vec_hold", vec_sel, e.vsel);
      chk("exc_code", exc_code, e.code);
      chk("epc_wr", epc_wr, k == 0);
      chk("mem_rd", mem_rd, k == 1);
      chk("pc_wr", pc_wr, k == 2 + ML);
      if (k == 0) chk("epc_out", epc_out, e.epc);
      if (k == 2 + ML) begin
        chk("pc_out", pc_out, e.pco);
        last_code = e.code;
        void'(q.pop_front());
      end
    end
  end
  initial begin
    vec_t v;
    int s;
    tbl[0] = '{0, 1, 0, 32'h104, 32'h5C, 2'b10, 3'b011, 32'h100, 32'h5C};
    tbl[1] = '{1, 1, 1, 32'h20, 32'hA7, 2'b01, 3'b010, 32'h1C, 32'hA7};
    tbl[2] = '{0, 0, 1, 32'h1000, 32'hFFFFFF33, 2'b11, 3'b100, 32'hFFC, 32'h33};
    tbl[3] = '{0, 1, 1, 32'h8, 32'h00, 2'b10, 3'b011, 32'h4, 32'h0};
    tbl[4] = '{1, 0, 1, 32'hFFFFFFFF, 32'h12345FF, 2'b01, 3'b010, 32'hFFFFFFFB, 32'hFF};
    reset = 0;
    step(3);
    chk("rst_outs", {vec_sel, mem_rd, epc_out, epc_wr, pc_out, pc_wr, exc_code, busy}, '0);
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_outs", {vec_sel, mem_rd, epc_out, epc_wr, pc_out, pc_wr, exc_code, busy}, '0);
    end
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    // div0 at pc 0 wraps; opcode pulse during WAIT must be ignored
    v = '{0, 0, 1, 32'h0, 32'h42, 2'b11, 3'b100, 32'hFFFFFFFC, 32'h42};
    drive(v);
    s = cyc + 1;
    push(v, s);
    step(1);
    exc_div0 = 0;
    step(2);
    exc_opcode = 1;
    step(1);
    exc_opcode = 0;
    step(8);
    // flag held across LOAD restarts after a single IDLE cycle
    v = '{0, 1, 0, 32'h204, 32'h77, 2'b10, 3'b011, 32'h200, 32'h77};
    drive(v);
    s = cyc + 1;
    push(v, s);
    push(v, s + 5);
    step(6);
    exc_overflow = 0;
    step(8);
    // reset during ADDR aborts the sequence
    v = '{0, 1, 0, 32'h304, 32'h99, 2'b10, 3'b011, 32'h300, 32'h99};
    drive(v);
    push(v, cyc + 1);
    step(1);
    exc_overflow = 0;
    step(1);
    chk("abort_in_addr", mem_rd, 1'b1);
    reset = 0;
    q.delete();
    last_code = 0;
    #1;
    chk("abort_outs", {vec_sel, mem_rd, epc_out, epc_wr, pc_out, pc_wr, exc_code, busy}, '0);
    step(1);
    reset = 1;
    step(8);
    // MEM_LATENCY=3 instance: pc_wr visible 5 cycles after sampling, write on edge 6
    pc_in = 32'h104;
    mem_data_in = 32'h5C;
    f3_ov = 1;
    step(1);
    f3_ov = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("ml3_pc_wr", pc_wr3, k == 5);
      chk("ml3_busy", busy3, k <= 5);
      if (k == 0) chk("ml3_epc", {epc_wr3, epc_out3, vec_sel3}, {1'b1, 32'h100, 3'b011});
      if (k == 5) chk("ml3_pc_out", {pc_out3, vec_sel3, exc_code3}, {32'h5C, 3'b011, 2'b10});
    end
    step(2);
`ifdef EXC_VECTOR_COUNT_EN
    reset = 0;
    q.delete();
    last_code = 0;
    step(1);
    chk("cnt_reset", exc_count, 8'd0);
    reset = 1;
    run_vec(tbl[0]);
    chk("cnt_one", exc_count, 8'd1);
    v = '{1, 0, 0, 32'h40, 32'h11, 2'b01, 3'b010, 32'h3C, 32'h11};
    drive(v);
    s = cyc + 1;
    for (int i = 0; i < 260; i++) push(v, s + 5 * i);
    step(1 + 5 * 259);
    exc_opcode = 0;
    step(8);
    chk("cnt_sat", exc_count, 8'd255);
    reset = 0;
    q.delete();
    last_code = 0;
    #1;
    chk("cnt_clear", exc_count, 8'd0);
    step(1);
    reset = 1;
    step(2);
`endif
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
